ce_rate_bridge: RTL
===================

CE_RATE_BRIDGE -- requirements
Module: ce_rate_bridge

Interface
REQ-001 Parameter DATA_W, default 8: data word width in bits.
REQ-002 Parameter DEPTH, default 4: FIFO entries, power of two, minimum 2.
REQ-003 iClk  input  1  single clock; all state updates on its rising edge.
REQ-004 iRsn  input  1  reset, asynchronous assert, active-low.
REQ-005 iEnable  input  1  clock-enable strobe, one iClk cycle wide, e.g. every 2nd cycle; the consumer-side rate.
REQ-006 iValid  input  1  producer write request, full clock rate.
REQ-007 iData  input  DATA_W  producer write data.
REQ-008 oReady  output  1  FIFO accepts a word this cycle.
REQ-009 oValid  output  1  oData holds a freshly popped word; single-cycle pulse.
REQ-010 oData  output  DATA_W  popped word; holds its value until the next pop.
REQ-011 oLevel  output  clog2(DEPTH+1)  current FIFO occupancy.
REQ-012 oDropCnt  output  8  saturating count of rejected writes.

Function
REQ-013 oReady SHALL equal (oLevel != DEPTH), taken combinationally from registered state at the start of the cycle.
REQ-014 A push SHALL occur on an edge where iValid=1 and oReady=1:
  - iData is written at the write pointer.
  - The write pointer advances modulo DEPTH.
REQ-015 A pop SHALL occur on an edge where iEnable=1 and oLevel!=0 at the start of the cycle:
  - The head entry loads into oData.
  - The read pointer advances modulo DEPTH.
  - oValid=1 for the following cycle only.
REQ-016 On any edge without a pop, oValid SHALL be 0 and oData SHALL keep its value.
REQ-017 Simultaneous push and pop SHALL both take effect, with oLevel unchanged.
REQ-018 When full, a write SHALL be rejected even if a pop occurs on the same edge.
  - The freed slot becomes available from the next cycle.
REQ-019 When empty, a push on the same edge as iEnable=1 SHALL NOT pop.
  - The word leaves on the next iEnable with non-empty FIFO.
  - Minimum push-to-oValid latency is therefore 2 cycles.
REQ-020 Words SHALL leave in exact push order with no duplication or loss of accepted words.
REQ-021 Each edge with iValid=1 and oReady=0 SHALL increment oDropCnt by 1.
  - oDropCnt saturates at 255 and never wraps.
REQ-022 iEnable SHALL be ignored when the FIFO is empty: no state change, oValid=0.
REQ-023 Back-to-back iEnable pulses (iEnable held high) SHALL pop one word per cycle while non-empty.
REQ-024 Pointers SHALL be clog2(DEPTH) bits wide and wrap silently.
  - Full/empty are derived from the occupancy counter only, never from pointer equality.

Reset
REQ-025 While iRsn=0, the following SHALL be held regardless of iClk:
  - read pointer, write pointer, oLevel and oDropCnt = 0.
  - oValid = 0 and oData = 0.
REQ-026 FIFO storage contents SHALL NOT require reset; no stale entry may ever be popped after reset.
REQ-027 Reset asserted mid-operation SHALL discard all buffered words.
  - The first pop after release returns the first word pushed after release.
REQ-028 oReady SHALL be 1 during and immediately after reset.

Verification
REQ-029 Single word:
  - Stimulus: push 0xA5 with iEnable pulsing every 2nd cycle.
  - Response: oValid pulses exactly once, oData=0xA5 at the first enable after the push, oLevel returns to 0.
REQ-030 Fill and drain:
  - Stimulus: push 0x01..0x04 on consecutive cycles with iEnable=0, then enable every 2nd cycle.
  - Response: oLevel=4 and oReady=0; outputs 0x01, 0x02, 0x03, 0x04 in order, one per enable.
REQ-031 Full with simultaneous pop:
  - Stimulus: FIFO full, iValid=1 with 0x55 and iEnable=1 on the same edge.
  - Response: 0x55 rejected, oDropCnt=1, oLevel=3; 0x55 is accepted on the next cycle.
REQ-032 Saturation:
  - Stimulus: hold iValid=1 for 300 cycles with iEnable=0.
  - Response: 4 accepted, oDropCnt=255 and stays 255.
REQ-033 Wrap-around:
  - Stimulus: stream 0x00..0x13 with iValid=1, iEnable every 2nd cycle, producer throttled by oReady.
  - Response: all 20 words out in order, none lost; oDropCnt counts only rejected cycles.
REQ-034 Reset mid-stream:
  - Stimulus: oLevel=3, pulse iRsn=0 asynchronously between edges, then push 0x7E.
  - Response: outputs clear immediately; the next oValid carries 0x7E.

Source files
------------

// File: rtl/ce_rate_bridge.sv
// ce_rate_bridge: single-clock FIFO that accepts producer words at full clock
// rate and releases them one per clock-enable strobe (the consumer rate).
// Rejected writes are counted in a saturating 8-bit drop counter.
module ce_rate_bridge #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       iClk,
    input  logic                       iRsn,
    input  logic                       iEnable,
    input  logic                       iValid,
    input  logic [DATA_W-1:0]          iData,
    output logic                       oReady,
    output logic                       oValid,
    output logic [DATA_W-1:0]          oData,
    output logic [$clog2(DEPTH+1)-1:0] oLevel,
    output logic [7:0]                 oDropCnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level;
    logic              push;
    logic              pop;
    logic              drop;

    // Handshake decisions come only from the registered occupancy, so a pop
    // on a full edge cannot free a slot for a write on that same edge, and a
    // push into an empty FIFO cannot be popped on that same edge.
    always_comb begin
        oReady = (level != LVL_W'(DEPTH));
        push   = iValid & oReady;
        pop    = iEnable & (level != '0);
        drop   = iValid & ~oReady;
        oLevel = level;
    end

    // Storage needs no reset: only entries written after reset are ever read,
    // because occupancy (not the array) decides what is valid.
    always_ff @(posedge iClk) begin
        if (push) begin
            mem[wr_ptr] <= iData;
        end
    end

    // Pointers, occupancy, output register and drop counter.
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            oValid   <= 1'b0;
            oData    <= '0;
            oDropCnt <= '0;
        end else begin
            oValid <= pop;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                oData  <= mem[rd_ptr];
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            if (drop && (oDropCnt != 8'hFF)) begin
                oDropCnt <= oDropCnt + 8'd1;
            end
        end
    end

endmodule
